systolic_feeder: RTL
====================

# systolic_feeder

Front-end sequencer and skew buffer that sits directly upstream of the dim×dim weight-stationary MAC array. It streams a weight tile into the array's top row with the weight-load control asserted, then feeds activation vectors into the array's left column with a one-cycle-per-row diagonal skew. It also generates per-column result-valid tags aligned to the bottom-row accumulator outputs, and drains the pipeline before signalling completion.

## Interface
- bit_width, 8, activation/weight element width
- dim, 4, array rows = array columns
- cnt_width, 16, width of vector count
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle start request; sampled only in IDLE
- num_vec  in  cnt_width  activation vectors to stream; sampled with start
- wt_in  in  dim*bit_width  one weight row; element c in bits [c*bit_width +: bit_width]
- wt_valid  in  1  wt_in valid
- wt_ready  out  1  feeder accepts wt_in
- act_in  in  dim*bit_width  one activation vector; element r drives array row r
- act_valid  in  1  act_in valid
- act_ready  out  1  feeder accepts act_in
- arr_ctrl  out  1  to all MAC control inputs (1 = weight load)
- arr_wt  out  dim*bit_width  to top-row weight-path inputs
- arr_data  out  dim*bit_width  to column-0 data inputs, skewed
- res_valid  out  dim  bit c: bottom acc output of column c valid this cycle
- busy  out  1  not in IDLE
- done  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, LOAD_WT, STREAM, DRAIN. Transitions:
  - IDLE→LOAD_WT on start. start is ignored in any other state.
  - LOAD_WT→STREAM after the dim-th weight accept. If num_vec==0, LOAD_WT→DRAIN instead.
  - STREAM→DRAIN after the num_vec-th activation accept.
  - DRAIN→IDLE after 2*dim cycles. done pulses in the first IDLE cycle.
- Weight load: wt_ready=1 in LOAD_WT until dim words have been accepted.
  - Words are sent bottom row first: word 0 is the weight row for array row dim-1, and word dim-1 is for row 0.
  - arr_ctrl is high only in the cycle after an accept. On a stall cycle arr_ctrl=0, which freezes the array's weight chain.
  - arr_wt holds the last accepted word. It is zero out of reset.
- Streaming: act_ready=1 in STREAM while the accepted count is less than num_vec.
  - Accepted element r enters a depth-r delay line (row 0 has no extra delay).
  - A non-accept cycle injects a zero element and a zero valid tag.
- Valid tags: each accept launches a tag. Tag delay to res_valid[c] is dim+c cycles relative to the row-0 presentation cycle.
- DRAIN: act_ready=0. Zeros are injected and the delay lines and tag pipeline keep shifting.
- Arithmetic: none. This is pure data movement; there is no width change.
- Reset (async, any state, mid-load or mid-stream): state=IDLE; all delay lines, tags and counters cleared.
  - Reset values: arr_ctrl=0, arr_wt=0, arr_data=0, res_valid=0, wt_ready=0, act_ready=0, busy=0, done=0.

## Timing
- All array-facing outputs are registered.
- Weight accept at edge E: arr_ctrl=1 and arr_wt=word during cycle E+1.
- Activation accept at edge E, with t=E+1:
  - arr_data row r = element r during cycle t+r.
  - res_valid[c]=1 during cycle t+dim+c.
- Last accept at edge E: DRAIN occupies cycles E+1…E+2*dim, which covers the final res_valid[dim-1] at E+2*dim. done=1 and busy=0 in cycle E+2*dim+1.
- Back-to-back accepts are permitted every cycle in both LOAD_WT and STREAM. There are no bubbles between the LOAD_WT and STREAM phases beyond the single state-change cycle.
- wt_ready and act_ready are combinational from state and counters only, never from the valid inputs.
- start in the same cycle as done is accepted, because the block is already in IDLE.

## Test plan
- Reset mid-STREAM with 3 vectors in flight -> next cycle all outputs are 0, busy=0; no res_valid ever appears.
- dim=4, start with num_vec=2, weights 0x04030201..0x10 sent with wt_valid continuously high -> arr_ctrl high for 4 consecutive cycles; arr_wt sequence equals the input order; wt_ready drops after the 4th accept.
- Weight stall: wt_valid low for 2 cycles between words 1 and 2 -> arr_ctrl=0 on both stall cycles; still exactly 4 arr_ctrl-high cycles in total.
- Activation 0x04030201 accepted at edge E -> arr_data row r = r+1 at cycle E+1+r; res_valid = 0001, 0010, 0100, 1000 at cycles E+5…E+8.
- act_valid toggled 1,0,1 with num_vec=2 -> a zero column is injected; res_valid[0] pulses at E+5 and E+7 only.
- num_vec=0 -> LOAD_WT then DRAIN for 8 cycles, done pulse; res_valid never asserted; a second start in the done cycle begins LOAD_WT.

Source files
------------

// File: rtl/systolic_feeder.sv
// Purpose: weight-tile loader and diagonal activation skew buffer feeding a dim x dim weight-stationary MAC array.
// Latency: weight word reaches arr_wt 1 cycle after accept; activation row r reaches arr_data 1+r cycles after accept; res_valid[c] follows at 1+dim+c.
// Backpressure: wt_ready/act_ready come from state and counters only; a stall injects zeros and leaves the weight chain frozen.
module systolic_feeder #(
    parameter int bit_width = 8,
    parameter int dim       = 4,
    parameter int cnt_width = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [cnt_width-1:0]     num_vec,
    input  logic [dim*bit_width-1:0] wt_in,
    input  logic                     wt_valid,
    output logic                     wt_ready,
    input  logic [dim*bit_width-1:0] act_in,
    input  logic                     act_valid,
    output logic                     act_ready,
    output logic                     arr_ctrl,
    output logic [dim*bit_width-1:0] arr_wt,
    output logic [dim*bit_width-1:0] arr_data,
    output logic [dim-1:0]           res_valid,
    output logic                     busy,
    output logic                     done
);

    localparam int WT_CW = $clog2(dim + 1);
    localparam int DR_CW = (2 * dim > 2) ? $clog2(2 * dim) : 1;
    localparam logic [cnt_width-1:0] VEC_ONE = cnt_width'(1);

    typedef enum logic [1:0] {IDLE, LOAD_WT, STREAM, DRAIN} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [WT_CW-1:0]     wt_cnt;
    logic [cnt_width-1:0] act_cnt;
    logic [cnt_width-1:0] num_q;
    logic [DR_CW-1:0]     drain_cnt;
    logic [2*dim-1:0]     tag;
    logic                 wt_acc;
    logic                 act_acc;
    logic                 wt_last;
    logic                 act_last;
    logic                 drain_last;

    assign wt_acc     = wt_ready & wt_valid;
    assign act_acc    = act_ready & act_valid;
    assign wt_last    = wt_acc && (wt_cnt == WT_CW'(dim - 1));
    assign act_last   = act_acc && ((act_cnt + VEC_ONE) == num_q);
    assign drain_last = (state == DRAIN) && (drain_cnt == DR_CW'(2 * dim - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode; readies never look at the valid inputs
    always_comb begin
        state_nxt = state;
        wt_ready  = 1'b0;
        act_ready = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) state_nxt = LOAD_WT;
            end
            LOAD_WT: begin
                wt_ready = (wt_cnt < WT_CW'(dim));
                if (wt_last) state_nxt = (num_q == '0) ? DRAIN : STREAM;
            end
            STREAM: begin
                act_ready = (act_cnt < num_q);
                if (act_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (drain_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Phase counters, captured vector count and the completion pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wt_cnt    <= '0;
            act_cnt   <= '0;
            num_q     <= '0;
            drain_cnt <= '0;
            done      <= 1'b0;
        end else begin
            done      <= drain_last;
            drain_cnt <= (state == DRAIN) ? drain_cnt + DR_CW'(1) : '0;
            if (state == IDLE && start) begin
                num_q   <= num_vec;
                wt_cnt  <= '0;
                act_cnt <= '0;
            end else begin
                if (wt_acc)  wt_cnt  <= wt_cnt + WT_CW'(1);
                if (act_acc) act_cnt <= act_cnt + VEC_ONE;
            end
        end
    end

    // Weight path: control pulses only on accepted words so stalls freeze the array's chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arr_ctrl <= 1'b0;
            arr_wt   <= '0;
        end else begin
            arr_ctrl <= wt_acc;
            if (wt_acc) arr_wt <= wt_in;
        end
    end

    // Valid-tag pipeline: tag[k] is the launch tag k cycles after row-0 presentation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag <= '0;
        end else begin
            tag <= {tag[2*dim-2:0], act_acc};
        end
    end

    assign res_valid = tag[2*dim-1:dim];

    // Per-row skew: row r sits behind r extra registers so each row lags the previous by one cycle
    for (genvar r = 0; r < dim; r++) begin : g_row
        logic [bit_width-1:0] dl [0:r];

        // Zero is injected whenever no activation is accepted, so idle and drain cycles flush the line
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k <= r; k++) dl[k] <= '0;
            end else begin
                dl[0] <= act_acc ? act_in[r*bit_width +: bit_width] : '0;
                for (int k = 1; k <= r; k++) dl[k] <= dl[k-1];
            end
        end

        assign arr_data[r*bit_width +: bit_width] = dl[r];
    end

endmodule
